// File: rtl/bus_pkg.sv
// Shared bus source codes and sequencer state encoding for the datapath bus.
package bus_pkg;

    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_R1     = 5'd1;
    localparam logic [4:0] SRC_R2     = 5'd2;
    localparam logic [4:0] SRC_R3     = 5'd3;
    localparam logic [4:0] SRC_R4     = 5'd4;
    localparam logic [4:0] SRC_R5     = 5'd5;
    localparam logic [4:0] SRC_R6     = 5'd6;
    localparam logic [4:0] SRC_R7     = 5'd7;
    localparam logic [4:0] SRC_R8     = 5'd8;
    localparam logic [4:0] SRC_R9     = 5'd9;
    localparam logic [4:0] SRC_R10    = 5'd10;
    localparam logic [4:0] SRC_R11    = 5'd11;
    localparam logic [4:0] SRC_R12    = 5'd12;
    localparam logic [4:0] SRC_R13    = 5'd13;
    localparam logic [4:0] SRC_R14    = 5'd14;
    localparam logic [4:0] SRC_R15    = 5'd15;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHIGH  = 5'd18;
    localparam logic [4:0] SRC_ZLOW   = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_C      = 5'd23;
    localparam logic [4:0] SRC_NONE   = 5'd31;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

endpackage

// File: rtl/src_decode_5_to_32.sv
// 5-to-32 one-hot source decoder; codes at or above NUM_SRC decode to all zeros.
module src_decode_5_to_32 #(
    parameter int NUM_SRC = 24
) (
    input  logic [4:0]  code,
    output logic [31:0] onehot
);

    localparam logic [5:0] NSRC = 6'(NUM_SRC);

    always_comb begin
        onehot = '0;
        if ({1'b0, code} < NSRC)
            onehot[code] = 1'b1;
    end

endmodule

// File: rtl/bus_drive_sequencer.sv
// Sequenced one-hot bus-source driver with a forced dead cycle between different sources.
module bus_drive_sequencer
    import bus_pkg::*;
#(
    parameter int NUM_SRC = 24,
    parameter int HOLD_W  = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_code,
    input  logic [HOLD_W-1:0] req_hold,
    output logic [31:0]       out_en,
    output logic [4:0]        bus_code,
    output logic              busy,
    output logic              err
);

    localparam logic [5:0] NSRC = 6'(NUM_SRC);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [4:0]        pend_code, pend_code_nxt;
    logic [HOLD_W-1:0] pend_hold, pend_hold_nxt;
    logic [4:0]        bus_code_nxt;
    logic [31:0]       out_en_nxt;
    logic              err_nxt;
    logic              accept, legal, reserved;

    // Remaining-cycle count loaded for a hold: 0 and 1 both mean a single cycle.
    function automatic logic [HOLD_W-1:0] hold_m1(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    // The registered out_en is always the decode of the next bus code, so
    // it cannot disagree with bus_code and is zero whenever bus_code is NONE.
    src_decode_5_to_32 #(.NUM_SRC(NUM_SRC)) u_dec (
        .code   (bus_code_nxt),
        .onehot (out_en_nxt)
    );

    always_comb begin
        req_ready     = (state == IDLE) || (state == DRIVE && cnt == '0);
        accept        = req_valid && req_ready;
        legal         = ({1'b0, req_code} < NSRC);
        reserved      = !legal && (req_code != SRC_NONE);
        state_nxt     = state;
        cnt_nxt       = cnt;
        pend_code_nxt = pend_code;
        pend_hold_nxt = pend_hold;
        bus_code_nxt  = bus_code;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                bus_code_nxt = SRC_NONE;
                if (accept && legal) begin
                    state_nxt    = DRIVE;
                    bus_code_nxt = req_code;
                    cnt_nxt      = hold_m1(req_hold);
                end else begin
                    err_nxt = accept && reserved;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (accept && legal && req_code == bus_code) begin
                    cnt_nxt = hold_m1(req_hold);
                end else if (accept && legal) begin
                    state_nxt     = TURN;
                    bus_code_nxt  = SRC_NONE;
                    pend_code_nxt = req_code;
                    pend_hold_nxt = req_hold;
                end else begin
                    state_nxt    = IDLE;
                    bus_code_nxt = SRC_NONE;
                    cnt_nxt      = '0;
                    err_nxt      = accept && reserved;
                end
            end
            TURN: begin
                state_nxt     = DRIVE;
                bus_code_nxt  = pend_code;
                cnt_nxt       = hold_m1(pend_hold);
                pend_code_nxt = SRC_NONE;
                pend_hold_nxt = '0;
            end
            default: begin
                state_nxt    = IDLE;
                bus_code_nxt = SRC_NONE;
                cnt_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_code <= SRC_NONE;
            pend_hold <= '0;
            bus_code  <= SRC_NONE;
            out_en    <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_code <= pend_code_nxt;
            pend_hold <= pend_hold_nxt;
            bus_code  <= bus_code_nxt;
            out_en    <= out_en_nxt;
            busy      <= (state_nxt != IDLE);
            err       <= err_nxt;
        end
    end

endmodule

// File: doc/bus_drive_sequencer.md
# bus_drive_sequencer

Sequenced 5-bit-code to one-hot bus-source driver for the datapath's shared bus: the inverse of the bus-select encoder. It accepts drive requests carrying a source code and a hold length. For the requested number of cycles it asserts exactly one out-enable (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C). It inserts a one-cycle dead cycle between different sources so that two drivers are never enabled in overlapping or adjacent cycles.

## Interface
- NUM_SRC, 24, number of legal source codes (0..NUM_SRC-1); codes NUM_SRC..30 are reserved; 31 = none
- HOLD_W, 4, width of the hold-length field
- clock  input  1  single clock; all state updates on rising edge
- clear  input  1  reset, asynchronous, active-low
- req_valid  input  1  drive request present
- req_ready  output  1  request accepted on an edge where req_valid && req_ready
- req_code  input  5  source code: 0–15 = R0–R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C, 31 none
- req_hold  input  HOLD_W  number of drive cycles; 0 is treated as 1
- out_en  output  32  registered one-hot source enables; bits 24–31 never asserted
- bus_code  output  5  registered code of the current driver; 31 when nothing is driven
- busy  output  1  registered; high in DRIVE or TURN
- err  output  1  one-cycle registered pulse on acceptance of a reserved code

## Operation
- States:
  - IDLE: req_ready=1, out_en=0.
  - DRIVE: out_en is one-hot, and cnt counts the remaining cycles.
  - TURN: out_en=0, bus_code=31, req_ready=0. Lasts exactly one cycle.
- Accepting a legal code in IDLE:
  - Next state is DRIVE.
  - out_en[code] and bus_code are set.
  - cnt = max(req_hold,1)-1.
- Accepting code 31 in IDLE: no-op, stay in IDLE, no err.
- Accepting a reserved code (NUM_SRC..30) in any state: err=1 for one cycle, nothing driven, next state is IDLE.
- DRIVE with cnt>0: req_ready=0 and cnt decrements.
- DRIVE with cnt==0 (last cycle): req_ready=1.
  - Same code accepted: reload cnt and stay in DRIVE. No gap; out_en stays continuous.
  - Different legal code accepted: latch code and hold into pending, go to TURN, then DRIVE with pending.
  - Code 31 accepted or no request: go to IDLE; out_en=0 from the next cycle.
- At most one bit of out_en is set in any cycle. A change of the set bit is always separated by at least one all-zero cycle.
- Hold arithmetic:
  - unsigned, width HOLD_W;
  - maximum drive length 2^HOLD_W-1 cycles;
  - hold 0 and hold 1 both give 1 cycle.

## Timing
- Reset: clear low asynchronously forces state=IDLE, out_en=0, bus_code=5'b11111, busy=0, err=0, cnt=0, pending cleared.
- Mid-drive reset drops out_en immediately, without waiting for a clock edge.
- Release: the first request is accepted on the first rising edge after clear goes high.
- Latency: a request accepted at edge k drives out_en in the cycle after edge k (1 cycle).
- Cycle counts:
  - a hold of H gives exactly max(H,1) cycles of out_en;
  - a different-source switch costs exactly 1 dead cycle;
  - a same-source back-to-back request costs 0.
- req_ready is combinational from state and cnt only, never from req_valid.
- busy and err are registered and aligned with out_en.

## Structure
- Shared package bus_pkg holds:
  - source-code localparams SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHIGH, SRC_ZLOW, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C, SRC_NONE=5'd31;
  - the state enum (IDLE, DRIVE, TURN).
- Sub-module src_decode_5_to_32: combinational 5-to-32 one-hot decoder that outputs all zeros for codes >= NUM_SRC. It feeds the out_en register.

## Test plan
- Reset mid-drive: start PC (20) with hold 5, pull clear low at cycle 2 → out_en=0 and bus_code=31 immediately; after release, a new request is accepted on the first edge.
- Single drive: accept R3 (code 3) with hold 3 → out_en=32'h0000_0008 for exactly 3 cycles, busy high for 3 cycles, then IDLE with out_en=0.
- Same-source chain: MDR (21) hold 2, then MDR hold 2 presented on the last cycle → out_en[21] high for 4 contiguous cycles.
- Switch: Zlow (19) hold 1, then R7 hold 2 on the last cycle → 1 cycle of bit 19, 1 all-zero cycle with bus_code=31, then 2 cycles of bit 7.
- Reserved/none: code 27 → err pulse of 1 cycle, out_en stays 0; code 31 → no err and no drive. Hold 0 on HI (16) → 1 drive cycle.
- Randomized requests with an assertion checker: $onehot0(out_en) every cycle, and never two different sources enabled in adjacent cycles.
